// File: rtl/ram_req_ctrl_if.sv
// Request/response channel between a master and the ram_req_ctrl front end.
// Requests carry reads and writes; read data returns in order on the response side.
`timescale 1ns/1ps
interface ram_req_ctrl_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_req_ctrl.sv
// Request front end for a single-port synchronous RAM with an in-order 2-entry read buffer.
// Define RAM_REQ_CTRL_CLEAR_EN to zero-fill the RAM after reset before accepting requests.
`timescale 1ns/1ps
module ram_req_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    ram_req_ctrl_if.slave     bus,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StRun   = 1'b1;

    logic [0:0]        state_q;
    logic              run;
    logic              req_ready;
    logic              rsp_valid;
    logic              accept;
    logic              push;
    logic              pop;
    logic              inflight_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic [1:0]        credit;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [DATA_W-1:0] buf_q [2];

`ifdef RAM_REQ_CTRL_CLEAR_EN
    logic [0:0]        state_d;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W-1:0] clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == StClear) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end
`else
    assign state_q = StRun;
`endif

    assign run  = (state_q == StRun);
    assign busy = ~run;

    // Outstanding reads (buffered plus one in the RAM pipeline) may never exceed the buffer.
    assign credit    = count_q + {1'b0, inflight_q};
    assign req_ready = run && !rst && (credit < 2'd2);
    assign accept    = bus.req_valid && req_ready;
    assign rsp_valid = (count_q != 2'd0);
    assign push      = inflight_q;
    assign pop       = rsp_valid && bus.rsp_ready;

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = buf_q[rd_ptr_q];

    always_comb begin
        ram_we   = accept && bus.req_we;
        ram_addr = bus.req_addr;
        ram_din  = bus.req_wdata;
`ifdef RAM_REQ_CTRL_CLEAR_EN
        if (state_q == StClear) begin
            ram_we   = !rst;
            ram_addr = clr_cnt_q;
            ram_din  = '0;
        end
`endif
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            inflight_q <= accept && !bus.req_we;
            count_q    <= count_d;
            // RAM output registered on the accept edge is captured one edge later.
            if (push) begin
                buf_q[wr_ptr_q] <= ram_dout;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count_q == 2'd2));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && count_q == 2'd0));

endmodule
